mac_pipeline: RTL and testbench
===============================

# mac_pipeline

Parametrised, stallable, pipelined multiply-accumulate unit for the PE datapath. It is the next generation of the two-slice pipelined multiplier and adds:
- a configurable number of operand-B slices;
- per-transaction signed/unsigned mode;
- a true valid pipeline that tracks every in-flight operand instead of a free-running ready counter;
- a wrap-around accumulator with a sticky overflow flag.

It sits between the PE scratchpads and the psum output path.

## Interface
- IN_W, 16, operand width in bits.
- SLICES, 2, number of B slices and partial-product stages. Must divide IN_W, range 1..IN_W.
- ACC_W, 40, accumulator width. Must be ≥ 2*IN_W.
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  when high, every pipeline register, valid bit, accumulator and flag holds
- in_valid  input  1  operand pair presented this cycle
- in_a  input  IN_W  multiplicand
- in_b  input  IN_W  multiplier
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; travels with the data
- in_acc_clear  input  1  this product starts a new accumulation; travels with the data
- prod_valid  output  1  product present on prod_out
- prod_out  output  2*IN_W  full-width product
- acc_valid  output  1  acc_out updated this cycle
- acc_out  output  ACC_W  running sum
- acc_ovf  output  1  sticky overflow since the last clear
- busy  output  1  OR of all internal valid bits

## Operation
- SW = IN_W/SLICES.
- Stage 0 captures in_a, in_b, in_signed, in_acc_clear and a valid bit, and computes partial 0.
- Stages 1..SLICES-1 each add one partial into a running 2*IN_W+1-bit sum.
- Partial k = A × slice_k(B) << (k*SW).
- Unsigned mode: A and every slice are zero-extended.
- Signed mode:
  - A is sign-extended.
  - Slices 0..SLICES-2 are zero-extended.
  - Slice SLICES-1 is treated as an SW-bit signed value.
- Output stage registers the truncated 2*IN_W-bit result into prod_out.
- Accumulator stage acts only when the product stage valid is set:
  - clear tag set: acc ← sext/zext(prod), acc_ovf ← 0;
  - otherwise: acc ← acc + sext/zext(prod), with extension chosen by the transaction's mode.
- Accumulator arithmetic wraps modulo 2^ACC_W.
- Overflow detection sets acc_ovf, which stays sticky until the next clear:
  - signed mode: operand signs equal and result sign differs;
  - unsigned mode: carry out of bit ACC_W-1.
- Bubbles (in_valid=0) propagate as invalid slots. Invalid slots never modify the accumulator or acc_ovf.
- Mixed signed/unsigned transactions may be interleaved back to back; each uses its own tag.

## Timing
- Reset value of every output is 0: prod_out, acc_out, prod_valid, acc_valid, acc_ovf, busy. All internal valid bits clear.
- Latency, counted in non-stalled cycles after in_valid is sampled with stall=0:
  - prod_valid rises SLICES+1 cycles later;
  - acc_valid rises SLICES+2 cycles later.
- Throughput is one operand pair per non-stalled cycle.
- in_valid is ignored while stall=1. The source must hold its data.
- Stall takes effect on the same edge. Outputs and valid levels are frozen and remain asserted while stalled.
- prod_valid and acc_valid are level signals qualifying the current cycle. Any cycle in which they are high with stall=0 counts as a delivered result.
- reset asserted mid-operation discards all in-flight data. busy falls immediately (asynchronously).
- SLICES=1 degenerates to a single multiply stage. Latency is then 2 for products and 3 for the accumulator.

## Structure
- Package mac_pkg:
  - SLICE_W(IN_W, SLICES) constant function;
  - mode encoding constants MODE_UNSIGNED=0, MODE_SIGNED=1;
  - typedef for the per-stage tag bundle {valid, signed, acc_clear}.
- Sub-module mac_slice_stage is instantiated SLICES times via generate. It holds one stage's registers, tag bundle and partial-product add.
- The top level contains the output register, accumulator and overflow logic.

## Test plan
All scenarios use IN_W=16, SLICES=2, ACC_W=40.
- Unsigned 0xFFFF × 0xFFFF -> prod_out=0xFFFE0001, prod_valid exactly 3 cycles after input.
- Signed 0x8000 × 0x8000 -> 0x40000000; signed 0xFFFF × 0x0002 -> 0xFFFFFFFE; unsigned 0xFFFF × 0x0002 -> 0x0001FFFE, issued back to back.
- Accumulate (2×3 with clear, 4×5, 6×7), unsigned -> acc_out 6, 26, 68 on consecutive acc_valid cycles.
- Stream of 4 products with stall held 3 cycles mid-stream and one bubble -> outputs frozen during stall, 4 results in order, no duplicates, bubble does not touch acc.
- 512 signed accumulations of 0x8000 × 0x8000 (first with clear) -> acc_out wraps to 0x8000000000 and acc_ovf=1; next clear -> acc_ovf=0.
- reset pulsed with 3 transactions in flight -> all outputs 0 immediately, no prod_valid afterwards until new input.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
package mac_pkg;

  // Operand mode encoding carried in each transaction's tag
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Per-stage tag bundle that travels alongside the operands
  typedef struct packed {
    logic valid;
    logic is_signed;
    logic acc_clear;
  } tag_t;

  // Width of one operand-B slice
  function automatic int SLICE_W(input int in_w, input int slices);
    return in_w / slices;
  endfunction

endpackage

// File: rtl/mac_slice_stage.sv
// One partial-product stage: multiplies A by slice K of B, adds it to the
// incoming running sum and registers operands, tag and sum for the next stage.
module mac_slice_stage
  import mac_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int SLICES = 2,
  parameter int K      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  tag_t              tag_i,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  input  logic [2*IN_W:0]   sum_i,
  output tag_t              tag_o,
  output logic [IN_W-1:0]   a_o,
  output logic [IN_W-1:0]   b_o,
  output logic [2*IN_W:0]   sum_o
);

  localparam int SW = SLICE_W(IN_W, SLICES);
  localparam int PW = 2 * IN_W + 1;

  logic [SW-1:0]   slice;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   b_ext;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   sum_d;

  tag_t            tag_q;
  logic [IN_W-1:0] a_q;
  logic [IN_W-1:0] b_q;
  logic [PW-1:0]   sum_q;

  // Extend A and this stage's B slice by mode, form the shifted partial and add it
  always_comb begin
    slice = b_i[K*SW +: SW];
    if (tag_i.is_signed == MODE_SIGNED) begin
      a_ext = {{(PW-IN_W){a_i[IN_W-1]}}, a_i};
    end else begin
      a_ext = {{(PW-IN_W){1'b0}}, a_i};
    end
    // Only the top slice carries the sign of B; lower slices are magnitude bits
    if ((tag_i.is_signed == MODE_SIGNED) && (K == SLICES - 1)) begin
      b_ext = {{(PW-SW){slice[SW-1]}}, slice};
    end else begin
      b_ext = {{(PW-SW){1'b0}}, slice};
    end
    partial = (a_ext * b_ext) << (K * SW);
    sum_d   = sum_i + partial;
  end

  // Stage register: everything holds while stalled, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (!stall) begin
      tag_q <= tag_i;
      a_q   <= a_i;
      b_q   <= b_i;
      sum_q <= sum_d;
    end
  end

  assign tag_o = tag_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/mac_pipeline.sv
// Stallable pipelined multiply-accumulate: SLICES partial-product stages,
// a product output register, and a wrap-around accumulator with sticky overflow.
module mac_pipeline
  import mac_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int SLICES = 2,
  parameter int ACC_W  = 40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_a,
  input  logic [IN_W-1:0]     in_b,
  input  logic                in_signed,
  input  logic                in_acc_clear,
  output logic                prod_valid,
  output logic [2*IN_W-1:0]   prod_out,
  output logic                acc_valid,
  output logic [ACC_W-1:0]    acc_out,
  output logic                acc_ovf,
  output logic                busy
);

  localparam int PW = 2 * IN_W + 1;

  // Inter-stage connections; index 0 is the pipeline input
  tag_t            tag_s [SLICES+1];
  logic [IN_W-1:0] a_s   [SLICES+1];
  logic [IN_W-1:0] b_s   [SLICES+1];
  logic [PW-1:0]   sum_s [SLICES+1];

  assign tag_s[0] = {in_valid, in_signed, in_acc_clear};
  assign a_s[0]   = in_a;
  assign b_s[0]   = in_b;
  assign sum_s[0] = '0;

  generate
    for (genvar gi = 0; gi < SLICES; gi++) begin : g_stage
      mac_slice_stage #(
        .IN_W   (IN_W),
        .SLICES (SLICES),
        .K      (gi)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .tag_i  (tag_s[gi]),
        .a_i    (a_s[gi]),
        .b_i    (b_s[gi]),
        .sum_i  (sum_s[gi]),
        .tag_o  (tag_s[gi+1]),
        .a_o    (a_s[gi+1]),
        .b_o    (b_s[gi+1]),
        .sum_o  (sum_s[gi+1])
      );
    end
  endgenerate

  // The last stage's operands and the sum's guard bit are not needed downstream
  logic unused_ok;
  assign unused_ok = ^{a_s[SLICES], b_s[SLICES], sum_s[SLICES][PW-1]};

  tag_t              prod_tag_q;
  logic [2*IN_W-1:0] prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic              acc_valid_q;
  logic              ovf_q;
  logic              ovf_d;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    acc_sum;
  logic              ovf_now;
  logic              stage_busy;

  // Product output register: truncated sum plus the transaction tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_tag_q <= '0;
      prod_q     <= '0;
    end else if (!stall) begin
      prod_tag_q <= tag_s[SLICES];
      prod_q     <= sum_s[SLICES][2*IN_W-1:0];
    end
  end

  // Accumulator next state: clear, add with wrap, and mode-dependent overflow
  always_comb begin
    prod_ext = (prod_tag_q.is_signed == MODE_UNSIGNED) ? ACC_W'(prod_q)
                                                        : ACC_W'($signed(prod_q));
    acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
    if (prod_tag_q.is_signed == MODE_SIGNED) begin
      ovf_now = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = acc_sum[ACC_W];
    end
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (prod_tag_q.valid) begin
      if (prod_tag_q.acc_clear) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  // Accumulator register: invalid slots leave the sum and flag untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else if (!stall) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      acc_valid_q <= prod_tag_q.valid;
    end
  end

  // Busy whenever any slot in the pipe holds a valid transaction
  always_comb begin
    stage_busy = 1'b0;
    for (int k = 1; k <= SLICES; k++) begin
      stage_busy = stage_busy | tag_s[k].valid;
    end
  end

  assign busy       = stage_busy | prod_tag_q.valid | acc_valid_q;
  assign prod_valid = prod_tag_q.valid;
  assign prod_out   = prod_q;
  assign acc_valid  = acc_valid_q;
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_mac_pipeline.sv
// Directed bench for mac_pipeline with IN_W=16, SLICES=2, ACC_W=40.
module tb_mac_pipeline;

  localparam int IN_W   = 16;
  localparam int SLICES = 2;
  localparam int ACC_W  = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              in_valid;
  logic [IN_W-1:0]   in_a;
  logic [IN_W-1:0]   in_b;
  logic              in_signed;
  logic              in_acc_clear;
  logic              prod_valid;
  logic [2*IN_W-1:0] prod_out;
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_ovf;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  // Stall-stream stimulus: five slots, slot 2 is a bubble
  bit [15:0] sa [5] = '{16'd3, 16'd7, 16'd0, 16'd2, 16'd10};
  bit [15:0] sb [5] = '{16'd5, 16'd11, 16'd0, 16'd9, 16'd10};
  bit        sv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit [31:0] exp_p [4] = '{32'd15, 32'd77, 32'd18, 32'd100};
  bit [39:0] exp_a [4] = '{40'd15, 40'd92, 40'd110, 40'd210};

  mac_pipeline #(
    .IN_W   (IN_W),
    .SLICES (SLICES),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_signed    (in_signed),
    .in_acc_clear (in_acc_clear),
    .prod_valid   (prod_valid),
    .prod_out     (prod_out),
    .acc_valid    (acc_valid),
    .acc_out      (acc_out),
    .acc_ovf      (acc_ovf),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c);
    in_valid     = v;
    in_a         = a;
    in_b         = b;
    in_signed    = s;
    in_acc_clear = c;
  endtask

  initial begin
    int j;
    int pcount;
    int acount;
    logic [31:0] snap_p;
    logic [39:0] snap_a;

    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_prod_valid", 64'(prod_valid), 64'd0);
    check("rst_prod_out",   64'(prod_out),   64'd0);
    check("rst_acc_valid",  64'(acc_valid),  64'd0);
    check("rst_acc_out",    64'(acc_out),    64'd0);
    check("rst_acc_ovf",    64'(acc_ovf),    64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);

    // Unsigned max x max, latency exactly 3 for product, 4 for accumulator
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("lat_c1_pv", 64'(prod_valid), 64'd0);
    check("lat_c1_busy", 64'(busy), 64'd1);
    tick();
    check("lat_c2_pv", 64'(prod_valid), 64'd0);
    tick();
    check("lat_c3_pv", 64'(prod_valid), 64'd1);
    check("umax_prod", 64'(prod_out), 64'hFFFE0001);
    check("lat_c3_av", 64'(acc_valid), 64'd0);
    tick();
    check("lat_c4_av", 64'(acc_valid), 64'd1);
    check("umax_acc", 64'(acc_out), 64'h00FFFE0001);
    check("lat_c4_pv", 64'(prod_valid), 64'd0);
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Mixed-mode back to back
    drive(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("s_min_prod", 64'(prod_out), 64'h40000000);
    tick();
    check("s_neg_prod", 64'(prod_out), 64'hFFFFFFFE);
    check("mix_acc0", 64'(acc_out), 64'h0040000000);
    tick();
    check("u_ffff2_prod", 64'(prod_out), 64'h0001FFFE);
    check("mix_acc1", 64'(acc_out), 64'h003FFFFFFE);
    tick();
    check("mix_acc2", 64'(acc_out), 64'h004001FFFC);
    check("mix_pv_low", 64'(prod_valid), 64'd0);
    tick();

    // Unsigned accumulate 2x3 (clear), 4x5, 6x7
    drive(1'b1, 16'd2, 16'd3, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'd4, 16'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'd6, 16'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    check("acc6_valid", 64'(acc_valid), 64'd1);
    check("acc6", 64'(acc_out), 64'd6);
    tick();
    check("acc26", 64'(acc_out), 64'd26);
    tick();
    check("acc68", 64'(acc_out), 64'd68);
    check("acc68_valid", 64'(acc_valid), 64'd1);
    tick();
    check("acc_done_valid", 64'(acc_valid), 64'd0);
    check("acc_hold", 64'(acc_out), 64'd68);

    // Stream with a bubble and a 3-cycle stall
    j = 0;
    pcount = 0;
    acount = 0;
    snap_p = '0;
    snap_a = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      stall = (cyc >= 4 && cyc < 7);
      if (j < 5) drive(sv[j], sa[j], sb[j], 1'b0, (j == 0));
      else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      if (cyc == 4) begin
        snap_p = prod_out;
        snap_a = acc_out;
      end
      if (cyc >= 5 && cyc <= 7) begin
        check("stall_prod_frozen", 64'(prod_out), 64'(snap_p));
        check("stall_acc_frozen",  64'(acc_out),  64'(snap_a));
        check("stall_pv_held",     64'(prod_valid), 64'd1);
        check("stall_av_held",     64'(acc_valid),  64'd1);
      end
      if (prod_valid && !stall) begin
        if (pcount < 4) check("stream_prod", 64'(prod_out), 64'(exp_p[pcount]));
        pcount++;
      end
      if (acc_valid && !stall) begin
        if (acount < 4) check("stream_acc", 64'(acc_out), 64'(exp_a[acount]));
        acount++;
      end
      tick();
      if (!stall) j++;
    end
    stall = 1'b0;
    check("stream_prod_count", 64'(pcount), 64'd4);
    check("stream_acc_count",  64'(acount), 64'd4);

    // 512 signed accumulations of 0x8000 x 0x8000: wraps to 2^39 with overflow
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 16'h8000, 16'h8000, 1'b1, (i == 0));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("wrap_pre_acc", 64'(acc_out), 64'h7FC0000000);
    check("wrap_pre_ovf", 64'(acc_ovf), 64'd0);
    tick();
    check("wrap_acc", 64'(acc_out), 64'h8000000000);
    check("wrap_ovf", 64'(acc_ovf), 64'd1);
    tick();
    check("wrap_ovf_sticky", 64'(acc_ovf), 64'd1);
    drive(1'b1, 16'd1, 16'd1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("clr_acc", 64'(acc_out), 64'd1);
    check("clr_ovf", 64'(acc_ovf), 64'd0);
    tick();

    // Reset pulsed with three transactions in flight
    drive(1'b1, 16'h1234, 16'h0010, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0004, 16'h0004, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_prod_valid", 64'(prod_valid), 64'd0);
    check("arst_prod_out",   64'(prod_out),   64'd0);
    check("arst_acc_valid",  64'(acc_valid),  64'd0);
    check("arst_acc_out",    64'(acc_out),    64'd0);
    check("arst_acc_ovf",    64'(acc_ovf),    64'd0);
    check("arst_busy",       64'(busy),       64'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_arst_pv", 64'(prod_valid), 64'd0);
    end
    drive(1'b1, 16'd5, 16'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("post_arst_prod", 64'(prod_out), 64'd25);
    check("post_arst_pv_new", 64'(prod_valid), 64'd1);
    tick();
    check("post_arst_acc", 64'(acc_out), 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
